// File: rtl/freq_meter.sv
// freq_meter: measures the frequency (rising Schmitt-trigger crossings per gate
// window) and the peak-to-peak amplitude of an 8-bit sampled waveform. Results
// are published once per window, and windows follow each other back-to-back.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int MID         = 128,
  parameter int HYST        = 8,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       adc_data,
  input  logic             adc_valid,
  input  logic             clr,
  output logic [CNT_W-1:0] freq,
  output logic [7:0]       vpp,
  output logic             ovf,
  output logic             meas_valid
);

  localparam int             GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EDGE_MAX = {CNT_W{1'b1}};
  localparam logic [8:0]     MID_TRIP  = 9'(MID);
  localparam logic [8:0]     HI_TRIP   = 9'(MID + HYST);
  localparam logic [8:0]     LO_TRIP   = 9'(MID - HYST);

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t           state, state_next;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_next;
  logic [7:0]       max_v, min_v, max_next, min_next, vpp_next;
  logic             trig, trig_next;
  logic             win_ovf, win_ovf_next;
  logic             has_sample, has_next;
  logic             terminal;
  logic [8:0]       sample;

  assign sample   = {1'b0, adc_data};
  assign vpp_next = has_next ? (max_next - min_next) : 8'd0;

  // Next-state logic plus the window contribution of the current sample.
  always_comb begin
    state_next   = state;
    trig_next    = trig;
    edge_next    = edge_cnt;
    win_ovf_next = win_ovf;
    max_next     = max_v;
    min_next     = min_v;
    has_next     = has_sample;
    terminal     = 1'b0;

    if (adc_valid) begin
      max_next = (adc_data > max_v) ? adc_data : max_v;
      min_next = (adc_data < min_v) ? adc_data : min_v;
      has_next = 1'b1;
    end

    case (state)
      INIT: begin
        if (adc_valid) begin
          trig_next  = (sample >= MID_TRIP);
          state_next = RUN;
        end
      end
      RUN: begin
        terminal = (gate_cnt == GATE_LAST);
        if (adc_valid) begin
          if (!trig && (sample >= HI_TRIP)) begin
            trig_next = 1'b1;
            if (edge_cnt == EDGE_MAX) begin
              win_ovf_next = 1'b1;
            end else begin
              edge_next = edge_cnt + CNT_W'(1);
            end
          end else if (trig && (sample <= LO_TRIP)) begin
            trig_next = 1'b0;
          end
        end
      end
      default: state_next = INIT;
    endcase

    if (clr) begin
      state_next = INIT;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Window accumulators, trigger state and published results.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      max_v      <= 8'd0;
      min_v      <= 8'd255;
      win_ovf    <= 1'b0;
      has_sample <= 1'b0;
      trig       <= 1'b0;
      freq       <= '0;
      vpp        <= 8'd0;
      ovf        <= 1'b0;
      meas_valid <= 1'b0;
    end else if (clr) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      max_v      <= 8'd0;
      min_v      <= 8'd255;
      win_ovf    <= 1'b0;
      has_sample <= 1'b0;
      trig       <= 1'b0;
      meas_valid <= 1'b0;
    end else if (state == INIT) begin
      meas_valid <= 1'b0;
      trig       <= trig_next;
      max_v      <= max_next;
      min_v      <= min_next;
      has_sample <= has_next;
      if (adc_valid) begin
        gate_cnt <= GW'(1);
      end
    end else begin
      trig <= trig_next;
      if (terminal) begin
        freq       <= edge_next;
        vpp        <= vpp_next;
        ovf        <= win_ovf_next;
        meas_valid <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        max_v      <= 8'd0;
        min_v      <= 8'd255;
        win_ovf    <= 1'b0;
        has_sample <= 1'b0;
      end else begin
        meas_valid <= 1'b0;
        gate_cnt   <= gate_cnt + GW'(1);
        edge_cnt   <= edge_next;
        win_ovf    <= win_ovf_next;
        max_v      <= max_next;
        min_v      <= min_next;
        has_sample <= has_next;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed tests for freq_meter with a 1000-cycle gate window.
// A second instance with a 4-bit edge counter shares the same stimulus so the
// saturation behaviour can be observed alongside the full-width result.
module tb_freq_meter;

  localparam int GATE = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        clr;
  logic [19:0] freq;
  logic [7:0]  vpp;
  logic        ovf;
  logic        meas_valid;
  logic [3:0]  freq4;
  logic [7:0]  vpp4;
  logic        ovf4;
  logic        meas_valid4;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Per-test pulse capture: step index and result values of each meas_valid.
  int          tcyc;
  int          pulse_n;
  int          pulse_at    [8];
  logic [31:0] pulse_freq  [8];
  logic [31:0] pulse_vpp   [8];
  logic [31:0] pulse_ovf   [8];
  logic [31:0] pulse_freq4 [8];
  logic [31:0] pulse_ovf4  [8];

  freq_meter #(.GATE_CYCLES(GATE), .MID(128), .HYST(8), .CNT_W(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .clr        (clr),
    .freq       (freq),
    .vpp        (vpp),
    .ovf        (ovf),
    .meas_valid (meas_valid)
  );

  freq_meter #(.GATE_CYCLES(GATE), .MID(128), .HYST(8), .CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .clr        (clr),
    .freq       (freq4),
    .vpp        (vpp4),
    .ovf        (ovf4),
    .meas_valid (meas_valid4)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, then samples outputs 1 unit after the edge
  // and records any measurement pulse with its step index.
  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic c, input logic r);
    adc_data  = d;
    adc_valid = v;
    clr       = c;
    rst_n     = r;
    @(posedge clk);
    #1;
    if (meas_valid) begin
      if (pulse_n < 8) begin
        pulse_at[pulse_n]    = tcyc;
        pulse_freq[pulse_n]  = 32'(freq);
        pulse_vpp[pulse_n]   = 32'(vpp);
        pulse_ovf[pulse_n]   = 32'(ovf);
        pulse_freq4[pulse_n] = 32'(freq4);
        pulse_ovf4[pulse_n]  = 32'(ovf4);
      end
      pulse_n++;
    end
    tcyc++;
  endtask

  // Clears the pulse log and restarts the step counter for a new test.
  task automatic startTest();
    pulse_n = 0;
    tcyc    = 0;
    for (int k = 0; k < 8; k++) begin
      pulse_at[k]    = -1;
      pulse_freq[k]  = 32'hFFFF_FFFF;
      pulse_vpp[k]   = 32'hFFFF_FFFF;
      pulse_ovf[k]   = 32'hFFFF_FFFF;
      pulse_freq4[k] = 32'hFFFF_FFFF;
      pulse_ovf4[k]  = 32'hFFFF_FFFF;
    end
  endtask

  task automatic doReset();
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd0, 1'b0, 1'b0, 1'b1);
    startTest();
  endtask

  // Square wave with 50 high / 50 low samples, phased so the stream opens low.
  function automatic logic [7:0] squareSample(input int i);
    return (((i + 50) % 100) < 50) ? 8'd255 : 8'd0;
  endfunction

  // Directed test sequence; all expected values are worked out by hand.
  initial begin
    logic [7:0] tri_val;
    int         m;
    startTest();

    // Reset state.
    doReset();
    checkOutput("reset_freq", 32'(freq), 0);
    checkOutput("reset_vpp", 32'(vpp), 0);
    checkOutput("reset_ovf", 32'(ovf), 0);
    checkOutput("reset_meas_valid", 32'(meas_valid), 0);

    // Square wave: rising crossings at steps 50,150,...; 10 per window.
    for (int i = 0; i < 2100; i++) applyStimulus(squareSample(i), 1'b1, 1'b0, 1'b0);
    checkOutput("sq_pulses", 32'(pulse_n), 2);
    checkOutput("sq_first_at", 32'(pulse_at[0]), 999);
    checkOutput("sq_second_at", 32'(pulse_at[1]), 1999);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("sq_freq%0d", k), pulse_freq[k], 10);
      checkOutput($sformatf("sq_vpp%0d", k), pulse_vpp[k], 255);
      checkOutput($sformatf("sq_ovf%0d", k), pulse_ovf[k], 0);
    end

    // In-band 125/131 samples never toggle the trigger.
    doReset();
    for (int i = 0; i < 3000; i++) applyStimulus((i % 2 == 0) ? 8'd125 : 8'd131, 1'b1, 1'b0, 1'b0);
    checkOutput("band_pulses", 32'(pulse_n), 3);
    checkOutput("band_third_at", 32'(pulse_at[2]), 2999);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("band_freq%0d", k), pulse_freq[k], 0);
      checkOutput($sformatf("band_vpp%0d", k), pulse_vpp[k], 6);
    end

    // Triangle, one sample every 2nd cycle, 1020-cycle period; idle cycles
    // carry a value of 200 that must be ignored. Rises land at 272+1020j.
    doReset();
    for (int i = 0; i < 4000; i++) begin
      m = (i / 2) % 510;
      tri_val = (m <= 255) ? 8'(m) : 8'(510 - m);
      if (i % 2 == 0) applyStimulus(tri_val, 1'b1, 1'b0, 1'b0);
      else            applyStimulus(8'd200, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("tri_pulses", 32'(pulse_n), 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("tri_freq%0d", k), pulse_freq[k], 1);
      checkOutput($sformatf("tri_vpp%0d", k), pulse_vpp[k], 255);
    end

    // 0/255 toggling gives 500 edges: full counter holds 500, 4-bit one
    // saturates at 15 with overflow; then a quiet all-zero window.
    doReset();
    for (int i = 0; i < 2000; i++)
      applyStimulus((i < 1000 && (i % 2 == 1)) ? 8'd255 : 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf_pulses", 32'(pulse_n), 2);
    checkOutput("ovf_freq_wide", pulse_freq[0], 500);
    checkOutput("ovf_ovf_wide", pulse_ovf[0], 0);
    checkOutput("ovf_vpp", pulse_vpp[0], 255);
    checkOutput("ovf_freq4", pulse_freq4[0], 15);
    checkOutput("ovf_ovf4", pulse_ovf4[0], 1);
    checkOutput("quiet_freq4", pulse_freq4[1], 0);
    checkOutput("quiet_ovf4", pulse_ovf4[1], 0);
    checkOutput("quiet_freq_wide", pulse_freq[1], 0);
    checkOutput("quiet_vpp", pulse_vpp[1], 0);

    // clr mid-window (step 1500) and on a terminal cycle (step 3500):
    // outputs hold, no pulse, restart on the next valid sample.
    doReset();
    for (int i = 0; i < 4600; i++) begin
      applyStimulus(squareSample(i), 1'b1, (i == 1500) || (i == 3500), 1'b0);
      if (i == 1500 || i == 3500) begin
        checkOutput($sformatf("clr_mv_%0d", i), 32'(meas_valid), 0);
        checkOutput($sformatf("clr_freq_hold_%0d", i), 32'(freq), 10);
        checkOutput($sformatf("clr_vpp_hold_%0d", i), 32'(vpp), 255);
      end
    end
    checkOutput("clr_pulses", 32'(pulse_n), 3);
    checkOutput("clr_at0", 32'(pulse_at[0]), 999);
    checkOutput("clr_at1", 32'(pulse_at[1]), 2500);
    checkOutput("clr_at2", 32'(pulse_at[2]), 4500);
    checkOutput("clr_freq1", pulse_freq[1], 10);
    checkOutput("clr_freq2", pulse_freq[2], 10);

    // One-cycle reset mid-window, then idle in INIT before sampling resumes.
    startTest();
    for (int i = 0; i < 300; i++) applyStimulus(squareSample(i), 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd255, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_freq", 32'(freq), 0);
    checkOutput("rst_vpp", 32'(vpp), 0);
    checkOutput("rst_ovf", 32'(ovf), 0);
    checkOutput("rst_meas_valid", 32'(meas_valid), 0);
    startTest();
    for (int i = 0; i < 1500; i++) applyStimulus(8'd255, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1100; i++) applyStimulus(squareSample(i), 1'b1, 1'b0, 1'b0);
    checkOutput("rst_pulses", 32'(pulse_n), 1);
    checkOutput("rst_at", 32'(pulse_at[0]), 2499);
    checkOutput("rst_freq_after", pulse_freq[0], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
